uart_tx_fifo: RTL and testbench

- Transmit-side byte buffer that sits directly upstream of UART_TX.
- Accepts bytes from the host at clock rate and stores them in a circular FIFO.
- Issues them to UART_TX one at a time using UART_TX's tx_start / data_in / tx_done handshake.
- Decouples bursty host writes from the slow serial line (9600 bps at 50 MHz system clock).

---
 rtl/uart_pkg.sv | 14 +
 rtl/sync_fifo.sv | 66 ++++++
 rtl/uart_tx_fifo.sv | 90 +++++++++
 tb/tb_uart_tx_fifo.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: constants and FSM state type shared by the UART blocks.
//   UART_DATA_WIDTH - byte width used by UART_TX/UART_RX and their FIFOs
//   CLOCK_RATE      - system clock frequency in Hz
//   BAUD_RATE       - serial line rate shared with Baud_Rate_Gen instances
//   tx_state_e      - issue FSM states of uart_tx_fifo
package uart_pkg;
    localparam int UART_DATA_WIDTH = 8;
    localparam int CLOCK_RATE = 50_000_000;
    localparam int BAUD_RATE = 9600;
    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_DONE = 1'b1
    } tx_state_e;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: circular register-array FIFO with separate occupancy counter.
//   clk, reset        - system clock, asynchronous active-high reset
//   wr_en, wr_data    - write strobe and data; ignored while full
//   rd_en, rd_data    - pop strobe; rd_data always shows the head entry
//   full, empty       - derived from the registered count
//   count             - entries stored (0..DEPTH)
//   overflow          - one-cycle pulse after a write that was dropped
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow
);
    localparam int CW = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  wr_acc, rd_acc;

    assign full     = count_q == CW'(DEPTH);
    assign empty    = count_q == '0;
    assign count    = count_q;
    assign overflow = overflow_q;
    assign rd_data  = mem_q[rd_ptr_q];
    // A pop in the same cycle never makes room for a write to a full FIFO.
    assign wr_acc   = wr_en && !full;
    assign rd_acc   = rd_en && !empty;

    always_comb begin
        wr_ptr_d   = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = rd_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q + CW'(wr_acc) - CW'(rd_acc);
        overflow_d = wr_en && full;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q] <= wr_data;
    end
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding UART_TX through its tx_start/tx_done handshake.
//   clk, reset              - system clock, asynchronous active-high reset
//   wr_en, wr_data          - host byte write, one per cycle
//   full, empty, count      - FIFO status (count excludes the byte in flight)
//   overflow                - one-cycle pulse after a dropped write
//   tx_start, tx_data       - start pulse and held byte toward UART_TX
//   tx_done                 - UART_TX completion flag (rising edge is used)
//   busy                    - a byte is in flight in UART_TX
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    parameter int DEPTH = 16,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  tx_start,
    output logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_done,
    output logic                  busy
);
    tx_state_e             state_q, state_d;
    logic                  tx_start_q, tx_start_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                  busy_q, busy_d;
    logic                  tx_done_q;
    logic [DATA_WIDTH-1:0] head;
    logic                  pop, done_rise;

    // Only a fresh rising edge completes a transfer; a level left high is stale.
    assign done_rise = tx_done && !tx_done_q;
    // The byte leaves the FIFO at issue time, not at completion.
    assign pop       = state_q == IDLE && !empty;

    sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (count),
        .overflow(overflow)
    );

    always_comb begin
        state_d    = state_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        busy_d     = busy_q;
        if (pop) begin
            state_d    = WAIT_DONE;
            tx_start_d = 1'b1;
            tx_data_d  = head;
            busy_d     = 1'b1;
        end else if (state_q == WAIT_DONE && done_rise) begin
            state_d = IDLE;
            busy_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            busy_q     <= 1'b0;
            tx_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            busy_q     <= busy_d;
            tx_done_q  <= tx_done;
        end
    end

    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign busy     = busy_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: table-driven and sequence checks of uart_tx_fifo with a byte-order scoreboard.
module tb_uart_tx_fifo;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = '0;
    logic       tx_done = 1'b0;
    logic       full, empty, overflow, tx_start, busy;
    logic [4:0] count;
    logic [7:0] tx_data;

    int n_cmp = 0;
    int n_bad = 0;
    int n_start = 0;
    logic [7:0] sb [$];

    typedef struct {
        logic       wr_en;
        logic [7:0] wr_data;
        logic       tx_done;
        logic       full;
        logic       empty;
        logic [4:0] count;
        logic       overflow;
        logic       tx_start;
        logic       busy;
    } vec_t;
    vec_t vecs [20];

    uart_tx_fifo dut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .full    (full),
        .empty   (empty),
        .count   (count),
        .overflow(overflow),
        .tx_start(tx_start),
        .tx_data (tx_data),
        .tx_done (tx_done),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wr_en = 1'b0;
        tx_done = 1'b0;
        cyc();
        cyc();
        sb.delete();
        reset = 1'b0;
    endtask

    task automatic wr(input logic [7:0] d);
        wr_en = 1'b1;
        wr_data = d;
        sb.push_back(d);
        cyc();
        wr_en = 1'b0;
    endtask

    task automatic pulse_done();
        tx_done = 1'b1;
        cyc();
        tx_done = 1'b0;
        cyc();
    endtask

    // Every issued byte must be the oldest accepted byte not yet issued.
    always @(negedge clk) begin
        if (tx_start) begin
            n_start++;
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_unexpected_start: got tx_data %0h with nothing expected", tx_data);
            end else begin
                chk("sb_tx_data", int'(tx_data), int'(sb.pop_front()));
            end
        end
    end

    initial begin
        int n0;
        vecs[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1};
        vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b1, 1'b1};
        vecs[7]  = '{1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 8'h04, 1'b0, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 5'd4, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 5'd4, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd3, 1'b0, 1'b1, 1'b1};
        vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd2, 1'b0, 1'b1, 1'b1};
        vecs[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b1, 1'b1};
        vecs[16] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1};
        vecs[18] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0};
        vecs[19] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0};

        do_reset();
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_tx_start", int'(tx_start), 0);
        chk("rst_tx_data", int'(tx_data), 0);
        chk("rst_busy", int'(busy), 0);

        // Single byte followed by a five-byte burst, one row per clock.
        for (int i = 0; i < 20; i++) begin
            wr_en = vecs[i].wr_en;
            wr_data = vecs[i].wr_data;
            tx_done = vecs[i].tx_done;
            if (vecs[i].wr_en) sb.push_back(vecs[i].wr_data);
            cyc();
            chk($sformatf("vec%0d.full", i), int'(full), int'(vecs[i].full));
            chk($sformatf("vec%0d.empty", i), int'(empty), int'(vecs[i].empty));
            chk($sformatf("vec%0d.count", i), int'(count), int'(vecs[i].count));
            chk($sformatf("vec%0d.overflow", i), int'(overflow), int'(vecs[i].overflow));
            chk($sformatf("vec%0d.tx_start", i), int'(tx_start), int'(vecs[i].tx_start));
            chk($sformatf("vec%0d.busy", i), int'(busy), int'(vecs[i].busy));
        end
        wr_en = 1'b0;
        tx_done = 1'b0;
        cyc();
        chk("vec_sb_left", sb.size(), 0);

        // Stale tx_done level must not complete the transfer.
        do_reset();
        tx_done = 1'b1;
        cyc();
        wr(8'h3C);
        cyc();
        chk("stale_start", int'(tx_start), 1);
        chk("stale_data", int'(tx_data), 'h3C);
        cyc();
        chk("stale_start_drop", int'(tx_start), 0);
        chk("stale_busy1", int'(busy), 1);
        cyc();
        chk("stale_busy2", int'(busy), 1);
        tx_done = 1'b0;
        cyc();
        chk("stale_busy3", int'(busy), 1);
        tx_done = 1'b1;
        cyc();
        chk("stale_done", int'(busy), 0);
        tx_done = 1'b0;
        cyc();

        // Full and overflow with tx_done held low.
        do_reset();
        for (int i = 0; i < 18; i++) begin
            wr_en = 1'b1;
            wr_data = 8'h10 + 8'(i);
            if (i < 17) sb.push_back(wr_data);
            cyc();
            if (i == 1) chk("ovf_first_start", int'(tx_start), 1);
            if (i == 16) begin
                chk("ovf_count16", int'(count), 16);
                chk("ovf_full", int'(full), 1);
                chk("ovf_early", int'(overflow), 0);
            end
            if (i == 17) begin
                chk("ovf_pulse", int'(overflow), 1);
                chk("ovf_count_hold", int'(count), 16);
            end
        end
        wr_en = 1'b0;
        cyc();
        chk("ovf_one_cycle", int'(overflow), 0);
        chk("ovf_still_full", int'(full), 1);
        repeat (17) pulse_done();
        chk("ovf_drain_empty", int'(empty), 1);
        chk("ovf_drain_busy", int'(busy), 0);
        chk("ovf_sb_left", sb.size(), 0);

        // Write on the issue edge with three bytes stored.
        do_reset();
        wr(8'h40);
        wr(8'h41);
        wr(8'h42);
        wr(8'h43);
        tx_done = 1'b1;
        cyc();
        tx_done = 1'b0;
        chk("simul_pre_count", int'(count), 3);
        chk("simul_pre_busy", int'(busy), 0);
        wr(8'h44);
        chk("simul_count", int'(count), 3);
        chk("simul_start", int'(tx_start), 1);
        repeat (4) pulse_done();
        chk("simul_empty", int'(empty), 1);
        chk("simul_sb_left", sb.size(), 0);

        // Reset while one byte is in flight and four are queued.
        do_reset();
        for (int i = 0; i < 6; i++) wr(8'h50 + 8'(i));
        pulse_done();
        chk("rmid_pre_start", int'(tx_start), 1);
        chk("rmid_pre_count", int'(count), 4);
        #2;
        reset = 1'b1;
        #1;
        chk("rmid_count", int'(count), 0);
        chk("rmid_empty", int'(empty), 1);
        chk("rmid_busy", int'(busy), 0);
        chk("rmid_tx_start", int'(tx_start), 0);
        sb.delete();
        n0 = n_start;
        cyc();
        cyc();
        reset = 1'b0;
        repeat (5) pulse_done();
        chk("rmid_no_starts", n_start - n0, 0);
        chk("rmid_empty_after", int'(empty), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
